// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
//   size_t  : access size encoding carried on req_size (byte/half/word/dword)
//   state_t : responder FSM state encoding, with the ST_* constants
//   DEFAULT_DEPTH / DEFAULT_WAIT_CYCLES : default parameter values
//   is_misaligned() : alignment rule for a given size and byte offset
package mem_resp_pkg;

  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 1;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_MERGE  = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // An access is aligned when the offset is a multiple of its size.
  function automatic logic is_misaligned(input size_t sz, input logic [2:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for a 64-bit little-endian word.
//   word      in  stored word (load source, or merge base)
//   offset    in  byte lane offset within the word
//   size      in  access size
//   zero_ext  in  1 = zero-extend loads, 0 = sign-extend (ignored for dword)
//   wdata     in  right-justified store data
//   load_data out extracted and extended load value
//   merged    out word with only the addressed lanes replaced by wdata
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  size_t       size,
  input  logic        zero_ext,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] mask;

  assign shamt   = {offset, 3'b000};
  assign shifted = word >> shamt;

  // NOTE: every output of a combinational block gets a default first so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_data = shifted;
    mask      = '1;
    case (size)
      SZ_B: begin
        mask      = 64'h0000_0000_0000_00FF;
        load_data = zero_ext ? {56'b0, shifted[7:0]}
                             : {{56{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        mask      = 64'h0000_0000_0000_FFFF;
        load_data = zero_ext ? {48'b0, shifted[15:0]}
                             : {{48{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        mask      = 64'h0000_0000_FFFF_FFFF;
        load_data = zero_ext ? {32'b0, shifted[31:0]}
                             : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        mask      = '1;
        load_data = shifted;
      end
    endcase
  end

  assign merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding-request data memory with valid/ready request and
// response channels and configurable wait states.
//   clock, reset                 rising-edge clock, async active-high reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_we, req_addr, req_size   store flag, byte address, access size
//   req_unsigned, req_wdata      load extension mode, right-justified data
//   rsp_valid/rsp_ready          response handshake (valid only in RESP)
//   rsp_rdata, rsp_err           extended load data, misaligned/range error
// Sub-word stores take an extra MERGE cycle: the word is read at the end of
// ACCESS, the addressed lanes are replaced, and the result written back.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  size_t         size_q;
  logic          uns_q;
  logic [63:0]   wdata_q;
  logic [AW-1:0] idx_q;
  logic [2:0]    off_q;
  logic [63:0]   word_q;

  logic [63:0]   mem [DEPTH];

  size_t         req_sz;
  logic [60:0]   req_word;
  logic          req_bad;
  logic [63:0]   rd_word;
  logic [63:0]   align_word;
  logic [63:0]   load_data;
  logic [63:0]   merged;
  logic          commit_dword;

  assign req_sz   = size_t'(req_size);
  assign req_word = req_addr[63:3];
  assign req_bad  = is_misaligned(req_sz, req_addr[2:0]) || (req_word >= 61'(DEPTH));

  assign rd_word    = mem[idx_q];
  assign align_word = (state == ST_MERGE) ? word_q : rd_word;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // The last ACCESS cycle of a full-width store is its commit edge.
  assign commit_dword = (state == ST_ACCESS) && (cnt == 4'd0) && we_q && (size_q == SZ_D);

  mem_lane_align u_align (
    .word      (align_word),
    .offset    (off_q),
    .size      (size_q),
    .zero_ext  (uns_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      idx_q     <= '0;
      off_q     <= 3'd0;
      word_q    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_sz;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            idx_q     <= req_addr[3 +: AW];
            off_q     <= req_addr[2:0];
            rsp_rdata <= '0;
            if (req_bad) begin
              // Bad requests skip the array entirely.
              state   <= ST_RESP;
              rsp_err <= 1'b1;
            end else begin
              state   <= ST_ACCESS;
              cnt     <= 4'(WAIT_CYCLES);
              rsp_err <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (we_q && (size_q != SZ_D)) begin
            word_q <= rd_word;
            state  <= ST_MERGE;
          end else begin
            rsp_rdata <= we_q ? 64'd0 : load_data;
            state     <= ST_RESP;
          end
        end
        ST_MERGE: state <= ST_RESP;
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and a
  // reset-less array maps onto RAM. Reset drives state to IDLE, which
  // removes both write enables, so an abandoned request never commits.
  always_ff @(posedge clock) begin
    if (commit_dword) begin
      mem[idx_q] <= wdata_q;
    end else if (state == ST_MERGE) begin
      mem[idx_q] <= merged;
    end
  end

endmodule
